ddr_frame_ring_ctrl: RTL and testbench

//  Parametrised N-buffer frame-ring controller; successor to the fixed 2-buffer odd/even scheme.

---
 rtl/frame_ring_pkg.sv | 48 ++++
 rtl/frame_ring_cmd_fifo.sv | 53 +++++
 rtl/ddr_frame_ring_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ddr_frame_ring_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_ring_pkg.sv
// rtl/frame_ring_pkg.sv - slot states, cmd field offsets and register map for the frame ring
// Slot encoding widens to 3 bits when ACC_STAGE_EN adds the accelerator states.
package frame_ring_pkg;

`ifdef ACC_STAGE_EN
  localparam int SLOT_W = 3;
  typedef enum logic [2:0] {
    SLOT_FREE    = 3'd0,
    SLOT_WRITING = 3'd1,
    SLOT_FULL    = 3'd2,
    SLOT_READING = 3'd3,
    SLOT_ACCEL   = 3'd4,
    SLOT_READY   = 3'd5
  } slot_state_e;
  localparam slot_state_e SLOT_RD_SRC = SLOT_READY;
`else
  localparam int SLOT_W = 2;
  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_WRITING = 2'd1,
    SLOT_FULL    = 2'd2,
    SLOT_READING = 2'd3
  } slot_state_e;
  localparam slot_state_e SLOT_RD_SRC = SLOT_FULL;
`endif

  typedef enum logic [2:0] {
    POS_SINGLE = 3'd0,
    POS_FIRST  = 3'd1,
    POS_MID    = 3'd2,
    POS_LAST   = 3'd3
  } cmd_pos_e;

  localparam int CMD_OK_BIT   = 60;
  localparam int CMD_WR_BIT   = 59;
  localparam int CMD_MDID_LSB = 52;
  localparam int CMD_ADDR_LSB = 32;

  localparam logic [19:0] REG_CTRL     = 20'd0;
  localparam logic [19:0] REG_STATUS   = 20'd1;
  localparam logic [19:0] REG_WR_CNT   = 20'd2;
  localparam logic [19:0] REG_RD_CNT   = 20'd3;
  localparam logic [19:0] REG_DROP_CNT = 20'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DROP = 1;

endpackage

// File: rtl/frame_ring_cmd_fifo.sv
// rtl/frame_ring_cmd_fifo.sv - synchronous FIFO for cmd responses and forwarded cmds
// Pushes while full and pops while empty are ignored.
module frame_ring_cmd_fifo #(
  parameter int W = 64,
  parameter int D = 4,
  localparam int AW = $clog2(D)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [AW:0]   o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(D));
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rp];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop_ok)  r_rp <= r_rp + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_frame_ring_ctrl.sv
// rtl/ddr_frame_ring_ctrl.sv - N-slot DDR frame ring handing slots to write/read adaptors
// Optional accelerator stage between FULL and read: ACC_STAGE_EN.
module ddr_frame_ring_ctrl
  import frame_ring_pkg::*;
#(
  parameter int                NUM_BUF    = 4,
  parameter int                IDX_W      = 3,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = ADDR_W'(32'h0080_0000),
  parameter logic [6:0]        MY_MDID    = 7'd5,
  parameter int                CMD_FIFO_D = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_wr_start_valid,
  input  logic              i_wr_start_ready,
  output logic [IDX_W-1:0]  o_wr_start_idx,
  output logic [ADDR_W-1:0] o_wr_start_addr,
  input  logic              i_wr_finish_valid,
  input  logic              i_wr_finish_ok,
  output logic              o_wr_finish_ready,
  output logic              o_rd_start_valid,
  input  logic              i_rd_start_ready,
  output logic [IDX_W-1:0]  o_rd_start_idx,
  output logic [ADDR_W-1:0] o_rd_start_addr,
  input  logic              i_rd_finish_valid,
  output logic              o_rd_finish_ready,
`ifdef ACC_STAGE_EN
  output logic              o_acc_start,
  output logic [IDX_W-1:0]  o_acc_idx,
  input  logic              i_acc_finish,
`endif
  input  logic              i_cmd_in_wr,
  input  logic [63:0]       i_cmd_in,
  output logic              o_cmd_in_alf,
  output logic              o_cmd_out_wr,
  output logic [63:0]       o_cmd_out,
  input  logic              i_cmd_out_alf
);

  localparam int FIFO_AW = $clog2(CMD_FIFO_D);
  localparam int NSLOT   = 2**IDX_W;
  localparam logic [FIFO_AW:0] ALF_LVL = (FIFO_AW+1)'(CMD_FIFO_D-2);

  slot_state_e       r_slot [NSLOT];
  logic [IDX_W-1:0]  r_wr_ptr;
  logic [IDX_W-1:0]  r_rd_ptr;
  logic              r_wr_start_valid;
  logic              r_wr_busy;
  logic              r_rd_busy;
  logic [1:0]        r_ctrl;
  logic [31:0]       r_wr_cnt;
  logic [31:0]       r_rd_cnt;
  logic [31:0]       r_drop_cnt;
  logic              r_cmd_out_wr;
  logic [63:0]       r_cmd_out;

  logic              w_wr_offer;
  logic              w_wr_hs;
  logic              w_wr_fin;
  logic              w_rd_valid;
  logic              w_rd_hs;
  logic              w_rd_fin;
  logic              w_reclaim;
  logic [31:0]       w_status;
  logic [31:0]       w_rdata;
  logic              w_addr_ok;
  logic [19:0]       w_addr;
  logic              w_mine;
  logic              w_is_wr;
  logic              w_accept;
  logic              w_reg_we;
  logic [63:0]       w_rsp;
  logic [63:0]       w_fifo_rdata;
  logic [FIFO_AW:0]  w_fifo_cnt;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_fifo_pop;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_BUF-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wr_offer = r_ctrl[CTRL_EN] && !r_wr_busy && !r_wr_start_valid &&
                      (r_slot[r_wr_ptr] == SLOT_FREE);
  assign w_wr_hs    = r_wr_start_valid && i_wr_start_ready;
  assign w_wr_fin   = r_wr_busy && i_wr_finish_valid;
  assign w_rd_valid = !r_rd_busy && (r_slot[r_rd_ptr] == SLOT_RD_SRC);
  assign w_rd_hs    = w_rd_valid && i_rd_start_ready;
  assign w_rd_fin   = r_rd_busy && i_rd_finish_valid;
  // A slot at wr_ptr that is still readable means the ring is full; an accepted read wins.
  assign w_reclaim  = r_ctrl[CTRL_EN] && r_ctrl[CTRL_DROP] && !r_wr_busy && !r_wr_start_valid &&
                      (r_slot[r_wr_ptr] == SLOT_RD_SRC) && !w_rd_hs && !r_rd_busy;

  assign o_wr_start_valid  = r_wr_start_valid;
  assign o_wr_start_idx    = r_wr_ptr;
  assign o_wr_start_addr   = BASE_ADDR + ADDR_W'(r_wr_ptr) * BUF_STRIDE;
  assign o_wr_finish_ready = r_wr_busy;
  assign o_rd_start_valid  = w_rd_valid;
  assign o_rd_start_idx    = r_rd_ptr;
  assign o_rd_start_addr   = BASE_ADDR + ADDR_W'(r_rd_ptr) * BUF_STRIDE;
  assign o_rd_finish_ready = r_rd_busy;

`ifdef ACC_STAGE_EN
  logic             r_acc_busy;
  logic [IDX_W-1:0] r_acc_ptr;
  logic             r_acc_start;
  logic [IDX_W-1:0] r_acc_idx;
  logic             w_acc_go;
  logic             w_acc_fin;

  assign w_acc_go    = !r_acc_busy && (r_slot[r_acc_ptr] == SLOT_FULL);
  assign w_acc_fin   = r_acc_busy && i_acc_finish;
  assign o_acc_start = r_acc_start;
  assign o_acc_idx   = r_acc_idx;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NSLOT; i++) r_slot[i] <= SLOT_FREE;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_wr_start_valid <= 1'b0;
      r_wr_busy        <= 1'b0;
      r_rd_busy        <= 1'b0;
`ifdef ACC_STAGE_EN
      r_acc_busy       <= 1'b0;
      r_acc_ptr        <= '0;
      r_acc_start      <= 1'b0;
      r_acc_idx        <= '0;
`endif
    end else begin
      if (w_wr_offer) r_wr_start_valid <= 1'b1;
      if (w_wr_hs) begin
        r_wr_start_valid   <= 1'b0;
        r_wr_busy          <= 1'b1;
        r_slot[r_wr_ptr]   <= SLOT_WRITING;
      end
      if (w_wr_fin) begin
        r_wr_busy <= 1'b0;
        if (i_wr_finish_ok) begin
          r_slot[r_wr_ptr] <= SLOT_FULL;
          r_wr_ptr         <= f_next(r_wr_ptr);
        end else begin
          r_slot[r_wr_ptr] <= SLOT_FREE;
        end
      end
      if (w_reclaim) begin
        r_slot[r_wr_ptr] <= SLOT_FREE;
        r_rd_ptr         <= f_next(r_rd_ptr);
      end
      if (w_rd_hs) begin
        r_rd_busy        <= 1'b1;
        r_slot[r_rd_ptr] <= SLOT_READING;
      end
      if (w_rd_fin) begin
        r_rd_busy        <= 1'b0;
        r_slot[r_rd_ptr] <= SLOT_FREE;
        r_rd_ptr         <= f_next(r_rd_ptr);
      end
`ifdef ACC_STAGE_EN
      r_acc_start <= w_acc_go;
      if (w_acc_go) begin
        r_acc_busy        <= 1'b1;
        r_acc_idx         <= r_acc_ptr;
        r_slot[r_acc_ptr] <= SLOT_ACCEL;
      end
      if (w_acc_fin) begin
        r_acc_busy        <= 1'b0;
        r_slot[r_acc_ptr] <= SLOT_READY;
        r_acc_ptr         <= f_next(r_acc_ptr);
      end
`endif
    end
  end

  always_comb begin
    w_status = '0;
    for (int i = 0; i < NUM_BUF; i++) w_status[i*SLOT_W +: SLOT_W] = r_slot[i];
    w_status[NUM_BUF*SLOT_W +: IDX_W]       = r_rd_ptr;
    w_status[NUM_BUF*SLOT_W+IDX_W +: IDX_W] = r_wr_ptr;
  end

  assign w_addr   = i_cmd_in[CMD_ADDR_LSB +: 20];
  assign w_mine   = (i_cmd_in[CMD_MDID_LSB +: 7] == MY_MDID);
  assign w_is_wr  = i_cmd_in[CMD_WR_BIT];
  assign w_accept = i_cmd_in_wr && !w_fifo_full;
  assign w_reg_we = w_accept && w_mine && w_is_wr;

  always_comb begin
    w_rdata   = '0;
    w_addr_ok = 1'b1;
    case (w_addr)
      REG_CTRL:     w_rdata = {30'd0, r_ctrl};
      REG_STATUS:   w_rdata = w_status;
      REG_WR_CNT:   w_rdata = r_wr_cnt;
      REG_RD_CNT:   w_rdata = r_rd_cnt;
      REG_DROP_CNT: w_rdata = r_drop_cnt;
      default:      w_addr_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_rsp = i_cmd_in;
    if (w_mine) begin
      w_rsp[CMD_OK_BIT] = w_addr_ok;
      w_rsp[31:0]       = !w_addr_ok ? 32'd0 : (w_is_wr ? i_cmd_in[31:0] : w_rdata);
    end
  end

  // Register write-clear takes precedence over a same-cycle count event.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ctrl     <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_reg_we && (w_addr == REG_CTRL)) r_ctrl <= i_cmd_in[1:0];
      if (w_reg_we && (w_addr == REG_WR_CNT))        r_wr_cnt <= '0;
      else if (w_wr_fin && i_wr_finish_ok)           r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_reg_we && (w_addr == REG_RD_CNT))        r_rd_cnt <= '0;
      else if (w_rd_fin)                             r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_reg_we && (w_addr == REG_DROP_CNT))      r_drop_cnt <= '0;
      else if (w_reclaim)                            r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign w_fifo_pop = !w_fifo_empty && !i_cmd_out_alf;

  frame_ring_cmd_fifo #(
    .W (64),
    .D (CMD_FIFO_D)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_accept),
    .i_wdata (w_rsp),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_cnt),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd_out_wr <= 1'b0;
      r_cmd_out    <= '0;
    end else begin
      r_cmd_out_wr <= w_fifo_pop;
      if (w_fifo_pop) r_cmd_out <= w_fifo_rdata;
    end
  end

  assign o_cmd_out_wr = r_cmd_out_wr;
  assign o_cmd_out    = r_cmd_out;
  assign o_cmd_in_alf = (w_fifo_cnt >= ALF_LVL);

endmodule

// File: tb/tb_ddr_frame_ring_ctrl.sv
// tb/tb_ddr_frame_ring_ctrl.sv - directed self-checking bench for ddr_frame_ring_ctrl
module tb_ddr_frame_ring_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        o_wr_start_valid, i_wr_start_ready;
  logic [2:0]  o_wr_start_idx;
  logic [31:0] o_wr_start_addr;
  logic        i_wr_finish_valid, i_wr_finish_ok, o_wr_finish_ready;
  logic        o_rd_start_valid, i_rd_start_ready;
  logic [2:0]  o_rd_start_idx;
  logic [31:0] o_rd_start_addr;
  logic        i_rd_finish_valid, o_rd_finish_ready;
  logic        i_cmd_in_wr, o_cmd_in_alf, o_cmd_out_wr, i_cmd_out_alf;
  logic [63:0] i_cmd_in, o_cmd_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ddr_frame_ring_ctrl dut (
    .i_clk             (clk),
    .i_reset           (i_reset),
    .o_wr_start_valid  (o_wr_start_valid),
    .i_wr_start_ready  (i_wr_start_ready),
    .o_wr_start_idx    (o_wr_start_idx),
    .o_wr_start_addr   (o_wr_start_addr),
    .i_wr_finish_valid (i_wr_finish_valid),
    .i_wr_finish_ok    (i_wr_finish_ok),
    .o_wr_finish_ready (o_wr_finish_ready),
    .o_rd_start_valid  (o_rd_start_valid),
    .i_rd_start_ready  (i_rd_start_ready),
    .o_rd_start_idx    (o_rd_start_idx),
    .o_rd_start_addr   (o_rd_start_addr),
    .i_rd_finish_valid (i_rd_finish_valid),
    .o_rd_finish_ready (o_rd_finish_ready),
    .i_cmd_in_wr       (i_cmd_in_wr),
    .i_cmd_in          (i_cmd_in),
    .o_cmd_in_alf      (o_cmd_in_alf),
    .o_cmd_out_wr      (o_cmd_out_wr),
    .o_cmd_out         (o_cmd_out),
    .i_cmd_out_alf     (i_cmd_out_alf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [63:0] cmd, output logic [63:0] rsp, output int lat);
    i_cmd_in_wr = 1'b1;
    i_cmd_in    = cmd;
    tick();
    i_cmd_in_wr = 1'b0;
    lat = 1;
    while (!o_cmd_out_wr && lat < 20) begin
      tick();
      lat++;
    end
    rsp = o_cmd_out;
    tick();
  endtask

  task automatic send_cmd(input logic wr, input logic [19:0] addr, input logic [31:0] data,
                          output logic [63:0] rsp, output int lat);
    send_raw({3'b000, 1'b0, wr, 7'd5, addr, data}, rsp, lat);
  endtask

  task automatic wr_frame(input logic ok, output logic [2:0] idx, output logic [31:0] addr);
    int k = 0;
    while (!o_wr_start_valid && k < 30) begin
      tick();
      k++;
    end
    check("wr_start_seen", o_wr_start_valid, 1'b1);
    idx  = o_wr_start_idx;
    addr = o_wr_start_addr;
    i_wr_start_ready = 1'b1;
    tick();
    i_wr_start_ready  = 1'b0;
    i_wr_finish_valid = 1'b1;
    i_wr_finish_ok    = ok;
    tick();
    i_wr_finish_valid = 1'b0;
    i_wr_finish_ok    = 1'b0;
  endtask

  task automatic rd_frame(output logic [2:0] idx);
    int k = 0;
    while (!o_rd_start_valid && k < 30) begin
      tick();
      k++;
    end
    check("rd_start_seen", o_rd_start_valid, 1'b1);
    idx = o_rd_start_idx;
    i_rd_start_ready = 1'b1;
    tick();
    i_rd_start_ready  = 1'b0;
    i_rd_finish_valid = 1'b1;
    tick();
    i_rd_finish_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rsp;
    logic [63:0] fwd;
    logic [2:0]  idx;
    logic [31:0] addr;
    int          lat;
    int          k;

    i_wr_start_ready = 0; i_wr_finish_valid = 0; i_wr_finish_ok = 0;
    i_rd_start_ready = 0; i_rd_finish_valid = 0;
    i_cmd_in_wr = 0; i_cmd_in = '0; i_cmd_out_alf = 0;
    do_reset();

    check("rst_wr_start_valid", o_wr_start_valid, 1'b0);
    check("rst_rd_start_valid", o_rd_start_valid, 1'b0);
    check("rst_wr_finish_ready", o_wr_finish_ready, 1'b0);
    check("rst_rd_finish_ready", o_rd_finish_ready, 1'b0);
    check("rst_cmd_out_wr", o_cmd_out_wr, 1'b0);
    check("rst_cmd_in_alf", o_cmd_in_alf, 1'b0);

    send_cmd(1'b1, 20'd0, 32'd1, rsp, lat);
    check("ctrl_wr_ok", rsp[60], 1'b1);
    check("ctrl_wr_lat", lat, 2);

    for (int n = 0; n < 4; n++) begin
      wr_frame(1'b1, idx, addr);
      check($sformatf("wr%0d_idx", n), idx, n);
      check($sformatf("wr%0d_addr", n), addr, n * 32'h0080_0000);
    end
    repeat (5) tick();
    check("stall_no_5th_wr", o_wr_start_valid, 1'b0);
    check("stall_rd_valid", o_rd_start_valid, 1'b1);
    check("stall_rd_idx", o_rd_start_idx, 3'd0);

    send_cmd(1'b0, 20'd2, 32'd0, rsp, lat);
    check("wr_cnt_ok", rsp[60], 1'b1);
    check("wr_cnt_4", rsp[31:0], 32'd4);
    check("rd_lat", lat, 2);

    fwd = {3'b101, 1'b0, 1'b1, 7'd3, 20'h12345, 32'hDEAD_BEEF};
    send_raw(fwd, rsp, lat);
    check("fwd_unchanged", rsp, fwd);

    send_cmd(1'b0, 20'd9, 32'h55, rsp, lat);
    check("bad_addr_rsp", rsp, {3'b000, 1'b0, 1'b0, 7'd5, 20'd9, 32'd0});

    send_cmd(1'b1, 20'd0, 32'd3, rsp, lat);
    wr_frame(1'b1, idx, addr);
    check("drop_wr5_idx", idx, 3'd0);
    send_cmd(1'b1, 20'd0, 32'd1, rsp, lat);
    wr_frame(1'b1, idx, addr);
    check("drop_wr6_idx", idx, 3'd1);
    repeat (5) tick();
    check("drop_off_stall", o_wr_start_valid, 1'b0);
    send_cmd(1'b0, 20'd4, 32'd0, rsp, lat);
    check("drop_cnt_2", rsp[31:0], 32'd2);
    send_cmd(1'b0, 20'd2, 32'd0, rsp, lat);
    check("wr_cnt_6", rsp[31:0], 32'd6);
    send_cmd(1'b0, 20'd1, 32'd0, rsp, lat);
    check("status_full_ring", rsp[31:0], 32'h0000_12AA);
    rd_frame(idx);
    check("first_rd_idx", idx, 3'd2);
    send_cmd(1'b0, 20'd3, 32'd0, rsp, lat);
    check("rd_cnt_1", rsp[31:0], 32'd1);
    send_cmd(1'b1, 20'd3, 32'd0, rsp, lat);
    send_cmd(1'b0, 20'd3, 32'd0, rsp, lat);
    check("rd_cnt_cleared", rsp[31:0], 32'd0);

    do_reset();
    send_cmd(1'b1, 20'd0, 32'd1, rsp, lat);
    wr_frame(1'b1, idx, addr);
    wr_frame(1'b0, idx, addr);
    check("abort_slot_idx", idx, 3'd1);
    k = 0;
    while (!o_wr_start_valid && k < 30) begin
      tick();
      k++;
    end
    check("abort_retry_valid", o_wr_start_valid, 1'b1);
    check("abort_retry_idx", o_wr_start_idx, 3'd1);
    send_cmd(1'b0, 20'd2, 32'd0, rsp, lat);
    check("abort_wr_cnt", rsp[31:0], 32'd1);

    check("pre_rd_valid", o_rd_start_valid, 1'b1);
    i_rd_start_ready = 1'b1;
    tick();
    i_rd_start_ready = 1'b0;
    check("reading_fin_ready", o_rd_finish_ready, 1'b1);
    i_reset = 1'b1;
    tick();
    check("rr_wr_start_valid", o_wr_start_valid, 1'b0);
    check("rr_rd_start_valid", o_rd_start_valid, 1'b0);
    check("rr_wr_finish_ready", o_wr_finish_ready, 1'b0);
    check("rr_rd_finish_ready", o_rd_finish_ready, 1'b0);
    check("rr_cmd_out_wr", o_cmd_out_wr, 1'b0);
    i_reset = 1'b0;
    i_rd_finish_valid = 1'b1;
    tick();
    i_rd_finish_valid = 1'b0;
    tick();
    check("late_fin_ready", o_rd_finish_ready, 1'b0);
    send_cmd(1'b0, 20'd1, 32'd0, rsp, lat);
    check("rr_status", rsp[31:0], 32'd0);
    send_cmd(1'b0, 20'd3, 32'd0, rsp, lat);
    check("rr_rd_cnt", rsp[31:0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
